// File: rtl/xor_serial_engine.sv
// rtl/xor_serial_engine.sv - digit-serial WIDTH-bit XOR under a start/busy/done handshake
// Optional result parity is built only when XOR_SERIAL_PARITY_EN is defined.
module xor_serial_engine #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             parity
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] r_next;
  logic             last_digit;

`ifdef XOR_SERIAL_PARITY_EN
  logic parity_q, parity_d;
`endif

  always_comb begin
    // The left shift drops everything but the low DIGIT bits of the XOR,
    // which land at the top of the result register.
    r_next     = (r_sh_q >> DIGIT) | ((a_sh_q ^ b_sh_q) << (WIDTH - DIGIT));
    last_digit = (cnt_q == CW'(K - 1));
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    r_sh_d     = r_sh_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
`ifdef XOR_SERIAL_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          r_sh_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        r_sh_d = r_next;
        cnt_d  = cnt_q + CW'(1);
        if (last_digit) begin
          res_d    = r_next;
`ifdef XOR_SERIAL_PARITY_EN
          parity_d = ^r_next;
`endif
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef XOR_SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef XOR_SERIAL_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
`ifdef XOR_SERIAL_PARITY_EN
  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_xor_serial_engine.sv
// tb/tb_xor_serial_engine.sv - bench for xor_serial_engine over three geometries
// Expected parity follows XOR_SERIAL_PARITY_EN.
module tb_xor_serial_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] st = '0;
  logic       a0 = 1'b0, b0 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;
  logic [2:0] busy, done, par;
  logic       res0;
  logic [7:0] res1, res2;

  always #5 clk = ~clk;

  xor_serial_engine #(.WIDTH(1), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .a(a0), .b(b0),
    .busy(busy[0]), .done(done[0]), .res(res0), .parity(par[0]));
  xor_serial_engine #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .a(a1), .b(b1),
    .busy(busy[1]), .done(done[1]), .res(res1), .parity(par[1]));
  xor_serial_engine #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .a(a2), .b(b2),
    .busy(busy[2]), .done(done[2]), .res(res2), .parity(par[2]));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h at %0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_a(input int i);
    return (i == 0) ? {7'b0, a0} : (i == 1) ? a1 : a2;
  endfunction
  function automatic logic [7:0] get_b(input int i);
    return (i == 0) ? {7'b0, b0} : (i == 1) ? b1 : b2;
  endfunction
  function automatic logic [7:0] get_res(input int i);
    return (i == 0) ? {7'b0, res0} : (i == 1) ? res1 : res2;
  endfunction

  // Model: an op accepted at edge E owns the unit until E+K+1 and lands at E+K.
  int         kk[3] = '{1, 8, 2};
  int         acc[3] = '{-1, -1, -1};
  logic [7:0] pend[3];
  logic [7:0] mres[3] = '{8'h00, 8'h00, 8'h00};
  logic       mpar[3] = '{1'b0, 1'b0, 1'b0};
  int         cyc = 0;

  always @(posedge clk) begin
    logic rst_s;
    logic eb, ed;
    cyc++;
    rst_s = rst;
    for (int i = 0; i < 3; i++) begin
      if (rst_s) begin
        acc[i]  = -1;
        mres[i] = 8'h00;
        mpar[i] = 1'b0;
      end else begin
        if (st[i] && (acc[i] < 0 || cyc >= acc[i] + kk[i] + 2)) begin
          acc[i]  = cyc;
          pend[i] = get_a(i) ^ get_b(i);
        end
        if (acc[i] >= 0 && cyc - acc[i] == kk[i]) begin
          mres[i] = pend[i];
`ifdef XOR_SERIAL_PARITY_EN
          mpar[i] = ^pend[i];
`endif
        end
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      eb = !rst_s && acc[i] >= 0 && (cyc - acc[i]) < kk[i];
      ed = !rst_s && acc[i] >= 0 && (cyc - acc[i]) == kk[i];
      chk("m_busy", i, {7'b0, busy[i]}, {7'b0, eb});
      chk("m_done", i, {7'b0, done[i]}, {7'b0, ed});
      chk("m_res", i, get_res(i), mres[i]);
      chk("m_par", i, {7'b0, par[i]}, {7'b0, mpar[i]});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       exp1[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_par_fe;
    int         ndone;
`ifdef XOR_SERIAL_PARITY_EN
    exp_par_fe = 8'h01;
`else
    exp_par_fe = 8'h00;
`endif
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, {7'b0, busy[i]}, 8'h00);
      chk("rst_done", i, {7'b0, done[i]}, 8'h00);
      chk("rst_res", i, get_res(i), 8'h00);
      chk("rst_par", i, {7'b0, par[i]}, 8'h00);
    end
    rst = 1'b0;

    // WIDTH=1: all four input pairs, done one cycle after start.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      st[0] = 1'b1; a0 = v[0]; b0 = v[1];
      @(posedge clk);
      @(negedge clk);
      st[0] = 1'b0;
      @(posedge clk); #1;
      chk("w1_done", v, {7'b0, done[0]}, 8'h01);
      chk("w1_res", v, {7'b0, res0}, {7'b0, exp1[v]});
      @(posedge clk);
    end

    // WIDTH=8 DIGIT=1: A5^0F, operands changed after acceptance.
    @(negedge clk);
    st[1] = 1'b1; a1 = 8'hA5; b1 = 8'h0F;
    @(posedge clk); #1;
    chk("t2_busy0", 0, {7'b0, busy[1]}, 8'h01);
    @(negedge clk);
    st[1] = 1'b0; a1 = 8'h00; b1 = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) begin
        chk("t2_busy", k, {7'b0, busy[1]}, 8'h01);
        chk("t2_done", k, {7'b0, done[1]}, 8'h00);
      end else begin
        chk("t2_done", k, {7'b0, done[1]}, 8'h01);
        chk("t2_busy", k, {7'b0, busy[1]}, 8'h00);
        chk("t2_res", k, res1, 8'hAA);
        chk("t2_par", k, {7'b0, par[1]}, 8'h00);
      end
    end
    @(posedge clk); #1;
    chk("t2_done_end", 9, {7'b0, done[1]}, 8'h00);
    chk("t2_res_hold", 9, res1, 8'hAA);

    // WIDTH=8 DIGIT=4: FF^01.
    @(negedge clk);
    st[2] = 1'b1; a2 = 8'hFF; b2 = 8'h01;
    @(posedge clk);
    @(negedge clk);
    st[2] = 1'b0;
    @(posedge clk); #1;
    chk("t3_done1", 1, {7'b0, done[2]}, 8'h00);
    @(posedge clk); #1;
    chk("t3_done", 2, {7'b0, done[2]}, 8'h01);
    chk("t3_res", 2, res2, 8'hFE);
    chk("t3_par", 2, {7'b0, par[2]}, exp_par_fe);
    repeat (2) @(posedge clk);

    // Start held high with moving operands: one op per 10 cycles.
    @(negedge clk);
    st[1] = 1'b1; a1 = 8'h13; b1 = 8'h5A;
    @(posedge clk);
    ndone = 0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      if (done[1]) ndone++;
      if (j == 8)  chk("t4_res_first", j, res1, 8'h49);
      if (j == 18) chk("t4_res_second", j, res1, 8'h71);
      @(negedge clk);
      a1 = a1 + 8'h1D;
      b1 = b1 ^ 8'h33;
    end
    chk("t4_ndone", 0, 8'(ndone), 8'd3);
    st[1] = 1'b0;
    repeat (12) @(posedge clk);

    // Reset in the middle of an operation.
    @(negedge clk);
    st[1] = 1'b1; a1 = 8'h3C; b1 = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    st[1] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_busy", 1, {7'b0, busy[1]}, 8'h00);
    chk("t5_done", 1, {7'b0, done[1]}, 8'h00);
    chk("t5_res", 1, res1, 8'h00);
    chk("t5_res2", 2, res2, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done[1]) ndone++;
    end
    chk("t5_no_done", 1, 8'(ndone), 8'd0);
    @(negedge clk);
    st[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_done_after", 1, {7'b0, done[1]}, 8'h01);
    chk("t5_res_after", 1, res1, 8'hFF);
    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_serial_engine.md
Name: xor_serial_engine

Overview:
- Parametrised, sequential successor to the single-bit combinational XOR cell.
- Computes the bitwise XOR of two WIDTH-bit operands, DIGIT bits per clock, through shift registers under a start/busy/done handshake.
- Sits beside the adder/XOR datapath cells as the area-lean multi-bit XOR unit.
- Optionally also produces the even-parity (XOR reduction) of the result.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 1.
- DIGIT, 1, bits processed per RUN cycle; WIDTH must be an integer multiple of DIGIT. K = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; latched on accepted start
- b  input  WIDTH  operand B; latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- res  output  WIDTH  registered result a^b; holds until next completion
- parity  output  1  XOR of all res bits (see Optional Feature)

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, res=0, parity=0, internal shift registers and counter=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at a rising edge -> latch a, b into shift registers, cnt=0, go to RUN. start=0 -> stay in IDLE.
  - RUN: each edge XORs the low DIGIT bits of both shift registers, inserts them at the top of the result shift register, shifts all three right by DIGIT, and increments cnt. On the edge with cnt=K-1: write the full result to res (and parity), go to DONE.
  - DONE: lasts exactly one cycle with done=1, then unconditionally goes to IDLE.
- Latency: for a start accepted at edge E0, res/done update at edge E0+K. busy=1 from E0 until E0+K. done=1 from E0+K until E0+K+1.
- Throughput: one operation per K+2 cycles (start can next be accepted at E0+K+2).
- Operands are LSB-first; digit i of res = digit i of a XOR digit i of b. Widths are exact, no extension.
- start while in RUN or DONE: ignored, with no queueing. a and b may change freely after acceptance without affecting the result.
- res and parity change only on the completion edge; otherwise they hold their last value, including through IDLE.
- Reset asserted mid-RUN: immediately returns to IDLE with all outputs 0. No done pulse is produced and the partial result is discarded.
- WIDTH=DIGIT (K=1): RUN lasts one edge, so done is high one cycle after the start edge.

Optional Feature:
- Macro: XOR_SERIAL_PARITY_EN.
- Defined: parity = reduction XOR of the final result. It is registered on the completion edge together with res and held alongside res.
- Undefined: parity is tied to 0 and no parity logic is built; all other behaviour is identical.

Test Plan:
- WIDTH=1, DIGIT=1; apply (a,b) = (0,0), (1,0), (0,1), (1,1) -> res = 0, 1, 1, 0; done pulses 1 cycle after each start edge.
- WIDTH=8, DIGIT=1; a=0xA5, b=0x0F, start at E0 -> busy=1 for edges E0..E0+8; res=0xAA and done=1 exactly at E0+8 for one cycle; parity=0 when the macro is defined.
- WIDTH=8, DIGIT=4; a=0xFF, b=0x01 -> res=0xFE at E0+2; parity=1 with the macro defined, 0 without it.
- WIDTH=8, DIGIT=1; hold start=1 continuously and change a/b during RUN -> exactly one operation per 10 cycles; each result uses the operands latched at its own accepting edge.
- Assert rst at E0+4 of an operation with a=0x3C, b=0xC3 -> busy, done and res are 0 immediately; no done pulse follows; next start gives the correct 0xFF.
